cirno9_iob_arb: RTL and testbench
=================================

# cirno9_iob_arb

Two-master, one-slave arbiter for the cirno9 IOB bus. It sits in front of a single IOB target, such as the IOB address splitter or a memory. It shares that target between two requesters, e.g. the instruction-fetch port (m0) and the load/store port (m1). It uses round-robin or fixed priority with one outstanding transaction at a time, plus a watchdog that completes hung transactions with an error.

## Interface
Parameters:
- `RR`, 1: 1 = round-robin between m0/m1; 0 = fixed priority, m0 wins.
- `TIMEOUT`, 255: slave cycles allowed before forced completion; 0 disables the watchdog. Counter width is `$clog2(TIMEOUT+1)`.
- `ERR_RDAT`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `m0_iob_val` in 1: m0 request valid; held until `m0_iob_rdy`.
- `m0_iob_rdy` out 1: m0 completion pulse, one cycle.
- `m0_iob_adr` in 32, `m0_iob_wen` in 4, `m0_iob_wdat` in 32: m0 address, byte write enables (0 = read), write data.
- `m0_iob_rdat` out 32: m0 read data, valid while `m0_iob_rdy`.
- `m1_iob_*`: same six ports as m0, for m1.
- `o_iob_val` out 1: slave request valid.
- `o_iob_rdy` in 1: slave completion pulse.
- `o_iob_adr` out 32, `o_iob_wen` out 4, `o_iob_wdat` out 32: slave address, byte enables, write data.
- `o_iob_rdat` in 32: slave read data, valid with `o_iob_rdy`.
- `err` out 1: one-cycle pulse when the watchdog forces a completion.

## Operation
- FSM states are IDLE and BUSY.
- IDLE:
  - Sample `m0_iob_val`/`m1_iob_val`.
  - If any is set, register `gnt` (0/1) and the winner's adr/wen/wdat into a request register, then go to BUSY.
  - If both are set: with RR=1 the master opposite `last` wins; with RR=0, m0 wins.
- BUSY:
  - `o_iob_val`=1 and `o_iob_adr/wen/wdat` come from the request register, stable for the whole transaction.
  - On `o_iob_rdy`: pulse `m<gnt>_iob_rdy` with `m<gnt>_iob_rdat` = `o_iob_rdat` in the same cycle (combinational return path). Then set `last`<=`gnt` and go to IDLE.
- Response routing:
  - The non-granted master's rdy is always 0.
  - Each master's rdat is 0 whenever its rdy is 0.
- Watchdog (TIMEOUT>0):
  - `wd_cnt` clears on entry to BUSY and increments each BUSY cycle without `o_iob_rdy`.
  - When `wd_cnt`==TIMEOUT-1 and no `o_iob_rdy`: pulse `m<gnt>_iob_rdy` with rdat=ERR_RDAT, pulse `err`, drop `o_iob_val`, go to IDLE.
  - If `o_iob_rdy` arrives in that same cycle, it is a normal completion: no err, slave data returned.
- Protocol violation: a master dropping val in BUSY is ignored. The slave transaction still completes and the response pulse is still issued to that master's rdy.
- Reset, from any state including mid-transaction:
  - state=IDLE, `o_iob_val`=0, `m0/m1_iob_rdy`=0, rdat=0, `err`=0.
  - `last`=1, so m0 wins the first tie.
  - `wd_cnt`=0, request register=0.
  - An in-flight slave response after reset is discarded.

## Timing
- Grant latency: a request sampled in IDLE at cycle N gives `o_iob_val`=1 at cycle N+1.
- Completion: `m_rdy` in the same cycle as `o_iob_rdy`.
- Master-visible latency = slave latency + 1 cycle.
- Back-to-back: after completion in cycle C, IDLE in C+1 arbitrates, and the next `o_iob_val` appears in C+2. There is one bubble cycle between transactions.
- `o_iob_val` is a register output. The slave sees a stable request from its first valid cycle until the cycle after its rdy.
- Timeout: rdy pulse and err in the TIMEOUT-th BUSY cycle. `o_iob_val`=0 from the next cycle.

## Structure
- Shared package `cirno9_iob_pkg`: IOB field widths (ADR_W=32, WEN_W=4, DAT_W=32), state encoding (IDLE, BUSY), and the ERR_RDAT default.
- One natural sub-module: `cirno9_rr_pick2`. It is a combinational two-way picker taking inputs req[1:0], last, RR and returning a one-hot grant.

## Test plan
- Single read: m0 val, adr=32'h100, wen=0; slave rdy 3 cycles after val with rdat=32'h1234_5678 → `m0_iob_rdy` pulse with rdat 32'h1234_5678. m1 rdy and rdat stay 0. Total latency 4 cycles.
- Tie, RR=1: both masters continuously requesting → grants alternate m0, m1, m0, m1. `o_iob_adr` matches the granted master. One bubble between transactions.
- Tie, RR=0: both requesting for 4 transactions → all 4 go to m0. m1 is served only after m0 drops val.
- Write passthrough: m1 wen=4'b0011, wdat=32'hAABB_CCDD, adr=32'h200 → slave sees exactly those fields, stable until rdy. Changing m1 inputs mid-BUSY does not change `o_iob_*`.
- Watchdog, TIMEOUT=8: slave never asserts rdy → in the 8th BUSY cycle master rdy pulses with rdat=32'hDEAD_BEEF and `err`=1, then `o_iob_val`=0. A slave rdy in exactly that cycle instead yields real data and err=0.
- Reset mid-BUSY: assert rst 2 cycles into a transaction → next cycle all outputs are 0. A late slave rdy is not forwarded. The first tie after reset goes to m0.

Source files
------------

// File: rtl/cirno9_iob_pkg.sv
// Shared IOB field widths, arbiter state encoding and the default timeout read data.
package cirno9_iob_pkg;
  localparam int ADR_W = 32;
  localparam int WEN_W = 4;
  localparam int DAT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [DAT_W-1:0] ERR_RDAT_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/cirno9_rr_pick2.sv
// Two-way grant picker: a single requester always wins, ties go by round-robin or to m0.
module cirno9_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic [1:0] gnt
);
  // One-hot grant; on a tie in round-robin mode the master that did not go last wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (rr && !last) ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/cirno9_iob_arb.sv
// Two-master, one-slave IOB arbiter with one outstanding transaction and a watchdog.
module cirno9_iob_arb
  import cirno9_iob_pkg::*;
#(
  parameter int               RR       = 1,
  parameter int               TIMEOUT  = 255,
  parameter logic [DAT_W-1:0] ERR_RDAT = ERR_RDAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m0_iob_val,
  output logic             m0_iob_rdy,
  input  logic [ADR_W-1:0] m0_iob_adr,
  input  logic [WEN_W-1:0] m0_iob_wen,
  input  logic [DAT_W-1:0] m0_iob_wdat,
  output logic [DAT_W-1:0] m0_iob_rdat,
  input  logic             m1_iob_val,
  output logic             m1_iob_rdy,
  input  logic [ADR_W-1:0] m1_iob_adr,
  input  logic [WEN_W-1:0] m1_iob_wen,
  input  logic [DAT_W-1:0] m1_iob_wdat,
  output logic [DAT_W-1:0] m1_iob_rdat,
  output logic             o_iob_val,
  input  logic             o_iob_rdy,
  output logic [ADR_W-1:0] o_iob_adr,
  output logic [WEN_W-1:0] o_iob_wen,
  output logic [DAT_W-1:0] o_iob_wdat,
  input  logic [DAT_W-1:0] o_iob_rdat,
  output logic             err
);
  // A zero TIMEOUT would give a zero-width counter; keep one dummy bit instead
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state;
  logic             gnt;
  logic             last;
  logic [WD_W-1:0]  wd_cnt;
  logic [ADR_W-1:0] req_adr;
  logic [WEN_W-1:0] req_wen;
  logic [DAT_W-1:0] req_wdat;
  logic [1:0]       pick;
  logic             busy;
  logic             wd_hit;
  logic             done;
  logic [DAT_W-1:0] rsp_dat;

  cirno9_rr_pick2 u_pick (
    .req  ({m1_iob_val, m0_iob_val}),
    .last (last),
    .rr   (RR != 0),
    .gnt  (pick)
  );

  assign busy    = (state == BUSY);
  // A slave rdy in the last allowed cycle wins over the watchdog
  assign wd_hit  = (TIMEOUT > 0) && busy && !o_iob_rdy && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign done    = busy && (o_iob_rdy || wd_hit);
  assign rsp_dat = wd_hit ? ERR_RDAT : o_iob_rdat;

  // Combinational return path: response lands in the slave's rdy cycle
  assign m0_iob_rdy  = done && !gnt;
  assign m1_iob_rdy  = done && gnt;
  assign m0_iob_rdat = m0_iob_rdy ? rsp_dat : '0;
  assign m1_iob_rdat = m1_iob_rdy ? rsp_dat : '0;
  assign err         = wd_hit;

  assign o_iob_adr  = req_adr;
  assign o_iob_wen  = req_wen;
  assign o_iob_wdat = req_wdat;

  // IDLE/BUSY control: latch the winner's request, hold it until the slave or watchdog completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_iob_val <= 1'b0;
      gnt       <= 1'b0;
      last      <= 1'b1;
      wd_cnt    <= '0;
      req_adr   <= '0;
      req_wen   <= '0;
      req_wdat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            gnt       <= pick[1];
            req_adr   <= pick[1] ? m1_iob_adr  : m0_iob_adr;
            req_wen   <= pick[1] ? m1_iob_wen  : m0_iob_wen;
            req_wdat  <= pick[1] ? m1_iob_wdat : m0_iob_wdat;
            wd_cnt    <= '0;
            o_iob_val <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            o_iob_val <= 1'b0;
            last      <= gnt;
            state     <= IDLE;
          end else if (TIMEOUT > 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cirno9_iob_arb.sv
// Bench for cirno9_iob_arb: instance 0 round-robin, instance 1 fixed priority, both TIMEOUT=8.
module tb_cirno9_iob_arb;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  logic m0v, m1v;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [3:0]  m0_wen, m1_wen;

  logic [1:0]  o_val, s_rdy, m0_rdy, m1_rdy, err_w;
  logic [31:0] o_adr[2], o_wdat[2], s_rdat[2], m0_rdat[2], m1_rdat[2];
  logic [3:0]  o_wen[2];

  // slave model controls: s_lat = valid cycles until rdy (0 = never)
  int   s_lat[2];
  int   s_cnt[2];
  bit   s_force[2];
  bit   s_fix;
  logic [31:0] s_dat;

  // transaction-level reference state per instance
  bit   mb[2], mg[2], ml[2];
  int   mcnt[2];
  logic [31:0] madr[2], mwdat[2];
  logic [3:0]  mwen[2];

  // {val, adr, wen, wdat} and {m0_rdy, m1_rdy, err, m0_rdat, m1_rdat}
  logic [68:0] act_req[2], exp_req[2];
  logic [66:0] act_rsp[2], exp_rsp[2];

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  cirno9_iob_arb #(.RR(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst),
    .m0_iob_val(m0v), .m0_iob_rdy(m0_rdy[0]), .m0_iob_adr(m0_adr), .m0_iob_wen(m0_wen),
    .m0_iob_wdat(m0_wdat), .m0_iob_rdat(m0_rdat[0]),
    .m1_iob_val(m1v), .m1_iob_rdy(m1_rdy[0]), .m1_iob_adr(m1_adr), .m1_iob_wen(m1_wen),
    .m1_iob_wdat(m1_wdat), .m1_iob_rdat(m1_rdat[0]),
    .o_iob_val(o_val[0]), .o_iob_rdy(s_rdy[0]), .o_iob_adr(o_adr[0]), .o_iob_wen(o_wen[0]),
    .o_iob_wdat(o_wdat[0]), .o_iob_rdat(s_rdat[0]), .err(err_w[0])
  );

  cirno9_iob_arb #(.RR(0), .TIMEOUT(TO)) u_fp (
    .clk(clk), .rst(rst),
    .m0_iob_val(m0v), .m0_iob_rdy(m0_rdy[1]), .m0_iob_adr(m0_adr), .m0_iob_wen(m0_wen),
    .m0_iob_wdat(m0_wdat), .m0_iob_rdat(m0_rdat[1]),
    .m1_iob_val(m1v), .m1_iob_rdy(m1_rdy[1]), .m1_iob_adr(m1_adr), .m1_iob_wen(m1_wen),
    .m1_iob_wdat(m1_wdat), .m1_iob_rdat(m1_rdat[1]),
    .o_iob_val(o_val[1]), .o_iob_rdy(s_rdy[1]), .o_iob_adr(o_adr[1]), .o_iob_wen(o_wen[1]),
    .o_iob_wdat(o_wdat[1]), .o_iob_rdat(s_rdat[1]), .err(err_w[1])
  );

  // One cycle, entered at a negedge: drive slaves, capture expected/actual, advance model.
  task automatic tick();
    logic to, done, r0, r1;
    logic [31:0] rd;
    for (int i = 0; i < 2; i++) begin
      if (o_val[i] === 1'b1) s_cnt[i]++; else s_cnt[i] = 0;
      s_rdy[i]  = s_force[i] || (o_val[i] === 1'b1 && s_lat[i] != 0 && s_cnt[i] == s_lat[i]);
      s_rdat[i] = s_fix ? s_dat : $urandom;
      s_force[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      to   = mb[i] && !s_rdy[i] && (mcnt[i] == TO - 1);
      done = mb[i] && (s_rdy[i] || to);
      rd   = to ? ERRD : s_rdat[i];
      r0   = done && !mg[i];
      r1   = done && mg[i];
      exp_req[i] = mb[i] ? {1'b1, madr[i], mwen[i], mwdat[i]} : 69'h0;
      exp_rsp[i] = {r0, r1, to, r0 ? rd : 32'h0, r1 ? rd : 32'h0};
      act_req[i] = (o_val[i] !== 1'b0) ? {o_val[i], o_adr[i], o_wen[i], o_wdat[i]} : 69'h0;
      act_rsp[i] = {m0_rdy[i], m1_rdy[i], err_w[i], m0_rdat[i], m1_rdat[i]};
      if (rst) begin
        mb[i] = 1'b0; ml[i] = 1'b1; mcnt[i] = 0;
      end else if (mb[i]) begin
        if (done) begin mb[i] = 1'b0; ml[i] = mg[i]; end
        else mcnt[i]++;
      end else if (m0v || m1v) begin
        // m1 takes a tie only under round-robin when m0 was served last
        mg[i]    = (m0v && m1v) ? (i == 0 && ml[i] == 1'b0) : m1v;
        madr[i]  = mg[i] ? m1_adr  : m0_adr;
        mwen[i]  = mg[i] ? m1_wen  : m0_wen;
        mwdat[i] = mg[i] ? m1_wdat : m0_wdat;
        mb[i]    = 1'b1;
        mcnt[i]  = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    m0v = 0; m1v = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    m0v = 0; m1v = 0; rst = 1;
    m0_adr = 0; m0_wen = 0; m0_wdat = 0; m1_adr = 0; m1_wen = 0; m1_wdat = 0;
    s_lat = '{0, 0}; s_force = '{0, 0}; s_fix = 0; s_dat = 0;
    tick();  // DUT state still unknown here
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 0;
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== 69'h0) $display("FAIL test_reset req inst%0d got=%h want=0", i, act_req[i]); else npass++;
        nchk++; if (act_rsp[i] !== 67'h0) $display("FAIL test_reset rsp inst%0d got=%h want=0", i, act_rsp[i]); else npass++;
      end
    end
  endtask

  task automatic test_single_read();
    bit got = 0;
    do_reset();
    s_fix = 1; s_dat = 32'h1234_5678; s_lat = '{3, 3};
    m0v = 1; m0_adr = 32'h100; m0_wen = 0; m0_wdat = 0;
    for (int n = 1; n <= 20 && !got; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL single_read req inst%0d got=%h want=%h", i, act_req[i], exp_req[i]); else npass++;
        nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL single_read rsp inst%0d got=%h want=%h", i, act_rsp[i], exp_rsp[i]); else npass++;
      end
      if (act_rsp[0][66] === 1'b1) begin
        got = 1; m0v = 0;
        nchk++; if (n != 4) $display("FAIL single_read latency got=%0d want=4", n); else npass++;
        nchk++; if (act_rsp[0][63:32] !== 32'h1234_5678) $display("FAIL single_read rdat got=%h want=12345678", act_rsp[0][63:32]); else npass++;
        nchk++; if (act_rsp[0][65] !== 1'b0 || act_rsp[0][31:0] !== 32'h0) $display("FAIL single_read m1_quiet got=%h want=0", act_rsp[0][65:0]); else npass++;
      end
    end
    if (!got) begin nchk++; $display("FAIL single_read timeout got=no_rdy want=rdy"); end
    s_fix = 0;
    repeat (2) tick();
  endtask

  task automatic test_tie();
    int qa[$], qb[$];
    logic [3:0] sa, sb;
    bit got = 0;
    do_reset();
    s_lat = '{2, 2};
    m0v = 1; m0_adr = 32'h1000; m0_wen = 0; m0_wdat = $urandom;
    m1v = 1; m1_adr = 32'h2000; m1_wen = 4'hF; m1_wdat = $urandom;
    for (int n = 0; n < 60 && (qa.size() < 4 || qb.size() < 4); n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL tie req inst%0d got=%h want=%h", i, act_req[i], exp_req[i]); else npass++;
        nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL tie rsp inst%0d got=%h want=%h", i, act_rsp[i], exp_rsp[i]); else npass++;
      end
      if (act_rsp[0][66] === 1'b1) qa.push_back(0);
      if (act_rsp[0][65] === 1'b1) qa.push_back(1);
      if (act_rsp[1][66] === 1'b1) qb.push_back(0);
      if (act_rsp[1][65] === 1'b1) qb.push_back(1);
    end
    sa = 4'hx; sb = 4'hx;
    if (qa.size() >= 4) for (int k = 0; k < 4; k++) sa[3-k] = qa[k][0];
    if (qb.size() >= 4) for (int k = 0; k < 4; k++) sb[3-k] = qb[k][0];
    nchk++; if (sa !== 4'b0101) $display("FAIL tie_rr order got=%b want=0101", sa); else npass++;
    nchk++; if (sb !== 4'b0000) $display("FAIL tie_fixed order got=%b want=0000", sb); else npass++;
    m0v = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL tie_drain rsp inst%0d got=%h want=%h", i, act_rsp[i], exp_rsp[i]); else npass++;
      end
      if (act_rsp[1][65] === 1'b1) got = 1;
    end
    nchk++; if (!got) $display("FAIL tie_fixed m1_served got=0 want=1"); else npass++;
    m1v = 0;
    repeat (4) tick();
  endtask

  task automatic test_write();
    bit got = 0;
    bit scr = 0;
    do_reset();
    s_lat = '{4, 4};
    m1v = 1; m1_adr = 32'h200; m1_wen = 4'b0011; m1_wdat = 32'hAABB_CCDD;
    for (int n = 0; n < 12 && !got; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL write req inst%0d got=%h want=%h", i, act_req[i], exp_req[i]); else npass++;
        nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL write rsp inst%0d got=%h want=%h", i, act_rsp[i], exp_rsp[i]); else npass++;
      end
      if (act_req[0][68] === 1'b1) begin
        nchk++;
        if (act_req[0] !== {1'b1, 32'h200, 4'b0011, 32'hAABB_CCDD})
          $display("FAIL write fields got=%h want=%h", act_req[0], {1'b1, 32'h200, 4'b0011, 32'hAABB_CCDD});
        else npass++;
        if (!scr) begin m1_adr = $urandom; m1_wen = 4'b1100; m1_wdat = $urandom; scr = 1; end
      end
      if (act_rsp[0][65] === 1'b1) begin got = 1; m1v = 0; end
    end
    if (!got) begin nchk++; $display("FAIL write timeout got=no_rdy want=rdy"); end
    repeat (2) tick();
  endtask

  task automatic test_watchdog();
    for (int pass = 0; pass < 2; pass++) begin
      int nb = 0;
      bit got = 0;
      do_reset();
      s_fix = 1; s_dat = 32'h5555_AAAA;
      s_lat = (pass == 0) ? '{0, 0} : '{TO, TO};
      m0v = 1; m0_adr = 32'h300; m0_wen = 0; m0_wdat = 0;
      for (int n = 0; n < 20 && !got; n++) begin
        tick();
        for (int i = 0; i < 2; i++) begin
          nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL watchdog req inst%0d got=%h want=%h", i, act_req[i], exp_req[i]); else npass++;
          nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL watchdog rsp inst%0d got=%h want=%h", i, act_rsp[i], exp_rsp[i]); else npass++;
        end
        if (act_req[0][68] === 1'b1) nb++;
        if (act_rsp[0][66] === 1'b1) begin
          got = 1; m0v = 0;
          nchk++; if (nb != TO) $display("FAIL watchdog busy_cycles got=%0d want=%0d", nb, TO); else npass++;
          nchk++; if (act_rsp[0][64] !== (pass == 0)) $display("FAIL watchdog err got=%b want=%b", act_rsp[0][64], pass == 0); else npass++;
          nchk++;
          if (act_rsp[0][63:32] !== ((pass == 0) ? ERRD : 32'h5555_AAAA))
            $display("FAIL watchdog rdat got=%h want=%h", act_rsp[0][63:32], (pass == 0) ? ERRD : 32'h5555_AAAA);
          else npass++;
        end
      end
      if (!got) begin nchk++; $display("FAIL watchdog timeout got=no_rdy want=rdy"); end
      tick();
      nchk++; if (act_req[0][68] !== 1'b0) $display("FAIL watchdog val_drop got=%b want=0", act_req[0][68]); else npass++;
    end
    s_fix = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_lat = '{0, 0};
    m0v = 1; m0_adr = 32'h400; m0_wen = 0;
    for (int n = 0; n < 4; n++) begin
      if (n == 3) begin rst = 1; m0v = 0; end
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL reset_mid req inst%0d got=%h want=%h", i, act_req[i], exp_req[i]); else npass++;
      end
    end
    rst = 0;
    m0v = 1; m0_adr = 32'h500; m1v = 1; m1_adr = 32'h600;
    s_force = '{1, 1};
    tick();
    for (int i = 0; i < 2; i++) begin
      nchk++; if (act_req[i] !== 69'h0) $display("FAIL reset_mid idle_req inst%0d got=%h want=0", i, act_req[i]); else npass++;
      nchk++; if (act_rsp[i] !== 67'h0) $display("FAIL reset_mid late_rdy inst%0d got=%h want=0", i, act_rsp[i]); else npass++;
    end
    m0v = 0; m1v = 0; s_lat = '{2, 2};
    tick();
    nchk++; if (act_req[0][68:36] !== {1'b1, 32'h500}) $display("FAIL reset_mid first_tie got=%h want=%h", act_req[0][68:36], {1'b1, 32'h500}); else npass++;
    repeat (3) tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      m0v = ($urandom_range(0, 2) != 0); m1v = ($urandom_range(0, 2) != 0);
      m0_adr = $urandom; m0_wen = 4'($urandom); m0_wdat = $urandom;
      m1_adr = $urandom; m1_wen = 4'($urandom); m1_wdat = $urandom;
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 2; i++) if (o_val[i] !== 1'b1) s_lat[i] = $urandom_range(1, TO + 1);
      tick();
      for (int i = 0; i < 2; i++) begin
        nchk++; if (act_req[i] !== exp_req[i]) $display("FAIL random req inst%0d cyc%0d got=%h want=%h", i, n, act_req[i], exp_req[i]); else npass++;
        nchk++; if (act_rsp[i] !== exp_rsp[i]) $display("FAIL random rsp inst%0d cyc%0d got=%h want=%h", i, n, act_rsp[i], exp_rsp[i]); else npass++;
      end
    end
    rst = 0; m0v = 0; m1v = 0;
  endtask

  initial begin
    rst = 1; m0v = 0; m1v = 0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
